// File: rtl/hd44780_pkg.sv
// Shared encodings and 48 MHz timing defaults for the HD44780 4-bit bus engines.
package hd44780_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_EHI   = 3'd2;
  localparam logic [2:0] ST_ELO   = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;

  localparam int DEF_SETUP_CYCLES = 3;
  localparam int DEF_EHIGH_CYCLES = 24;
  localparam int DEF_ELOW_CYCLES  = 24;
  localparam int DEF_HOLD_CYCLES  = 2;
  localparam int DEF_MAX_POLLS    = 4096;

  localparam int BF_BIT = 7;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/hd44780_phase_timer.sv
// Loadable down-counter; done is high on the last cycle of a loaded phase.
module hd44780_phase_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  // A phase loaded with N lasts exactly N cycles, the last one flagged here.
  assign done = (cnt == W'(1));

endmodule

// File: rtl/hd44780_reader.sv
// HD44780 4-bit read engine: two E strobes per byte, optional busy-flag polling.
module hd44780_reader
  import hd44780_pkg::*;
#(
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int EHIGH_CYCLES = DEF_EHIGH_CYCLES,
  parameter int ELOW_CYCLES  = DEF_ELOW_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int MAX_POLLS    = DEF_MAX_POLLS
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_rs,
  input  logic       i_poll,
  output logic       o_busy,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_timeout,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic       o_lcd_dir,
  input  logic [3:0] i_lcd_data
);

  localparam int MAXP = max4(SETUP_CYCLES, EHIGH_CYCLES, ELOW_CYCLES, HOLD_CYCLES);
  localparam int PW   = $clog2(MAXP + 1);
  localparam int CW   = $clog2(MAX_POLLS + 1);

  logic [2:0]    state;
  logic          nibble;
  logic          poll_l;
  logic          tflag;
  logic [CW-1:0] count;
  logic [3:0]    data_q;
  logic          t_load;
  logic [PW-1:0] t_val;
  logic          t_done;
  logic          repoll;
  logic          more;

  assign more   = (int'(count) + 1) < MAX_POLLS;
  assign repoll = poll_l && o_data[BF_BIT] && more;

  hd44780_phase_timer #(.W(PW)) u_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  // Timer loads coincide with the state transitions below.
  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    case (state)
      ST_IDLE:  if (i_req)  begin t_load = 1'b1; t_val = PW'(SETUP_CYCLES); end
      ST_SETUP: if (t_done) begin t_load = 1'b1; t_val = PW'(EHIGH_CYCLES); end
      ST_EHI:   if (t_done) begin t_load = 1'b1; t_val = PW'(ELOW_CYCLES);  end
      ST_ELO:   if (t_done && !nibble) begin t_load = 1'b1; t_val = PW'(EHIGH_CYCLES); end
      ST_CHECK: begin
        t_load = 1'b1;
        t_val  = repoll ? PW'(EHIGH_CYCLES) : PW'(HOLD_CYCLES);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      nibble    <= 1'b0;
      poll_l    <= 1'b0;
      tflag     <= 1'b0;
      count     <= '0;
      data_q    <= 4'h0;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= 8'h00;
      o_timeout <= 1'b0;
      o_lcd_rs  <= 1'b0;
      o_lcd_rw  <= 1'b0;
      o_lcd_e   <= 1'b0;
      o_lcd_dir <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      data_q    <= i_lcd_data;
      case (state)
        ST_IDLE: if (i_req) begin
          poll_l    <= i_poll;
          o_lcd_rs  <= i_rs;
          count     <= '0;
          tflag     <= 1'b0;
          nibble    <= 1'b0;
          o_busy    <= 1'b1;
          o_lcd_rw  <= 1'b1;
          o_lcd_dir <= 1'b1;
          state     <= ST_SETUP;
        end
        ST_SETUP: if (t_done) begin
          o_lcd_e <= 1'b1;
          state   <= ST_EHI;
        end
        ST_EHI: if (t_done) begin
          if (nibble) o_data[3:0] <= data_q;
          else        o_data[7:4] <= data_q;
          o_lcd_e <= 1'b0;
          state   <= ST_ELO;
        end
        ST_ELO: if (t_done) begin
          if (!nibble) begin
            nibble  <= 1'b1;
            o_lcd_e <= 1'b1;
            state   <= ST_EHI;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (repoll) begin
            if (count != '1) count <= count + CW'(1);
            nibble  <= 1'b0;
            o_lcd_e <= 1'b1;
            state   <= ST_EHI;
          end else begin
            // Still busy here means the poll budget ran out.
            if (poll_l && o_data[BF_BIT]) tflag <= 1'b1;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: if (t_done) begin
          o_lcd_rw  <= 1'b0;
          o_lcd_dir <= 1'b0;
          o_lcd_rs  <= 1'b0;
          o_busy    <= 1'b0;
          o_valid   <= 1'b1;
          o_timeout <= tflag;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_reader.sv
// Directed bench: scripted LCD nibble model, latency/strobe/poll/reset checks.
module tb_hd44780_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       req = 1'b0, rs = 1'b0, poll = 1'b0;
  logic       busy, valid, timeout, lrs, lrw, le, ldir;
  logic [7:0] data;
  logic [3:0] ld = 4'h0;

  logic       req4 = 1'b0, rs4 = 1'b0, poll4 = 1'b0;
  logic       busy4, valid4, timeout4, lrs4, lrw4, le4, ldir4;
  logic [7:0] data4;
  logic [3:0] ld4 = 4'h8;

  hd44780_reader dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_rs(rs), .i_poll(poll),
    .o_busy(busy), .o_valid(valid), .o_data(data), .o_timeout(timeout),
    .o_lcd_rs(lrs), .o_lcd_rw(lrw), .o_lcd_e(le), .o_lcd_dir(ldir),
    .i_lcd_data(ld)
  );

  hd44780_reader #(.MAX_POLLS(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_req(req4), .i_rs(rs4), .i_poll(poll4),
    .o_busy(busy4), .o_valid(valid4), .o_data(data4), .o_timeout(timeout4),
    .o_lcd_rs(lrs4), .o_lcd_rw(lrw4), .o_lcd_e(le4), .o_lcd_dir(ldir4),
    .i_lcd_data(ld4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // LCD model: presents the next scripted nibble at each E rise, measures E pulses.
  logic [3:0] script [8];
  logic       clr = 1'b0;
  logic       exp_rs = 1'b0;
  logic       e_prev = 1'b0, e4_prev = 1'b0;
  int         idx = 0, w = 0, npulse = 0, bad_w = 0, rs_bad = 0, npulse4 = 0;

  always @(negedge clk) begin
    e_prev  <= le;
    e4_prev <= le4;
    if (clr) begin
      idx <= 0; w <= 0; npulse <= 0; bad_w <= 0; rs_bad <= 0; npulse4 <= 0;
    end else begin
      if (le && !e_prev) begin
        ld  <= script[idx[2:0]];
        idx <= idx + 1;
      end
      if (le) w <= w + 1;
      else if (e_prev) begin
        npulse <= npulse + 1;
        if (w != 24) bad_w <= bad_w + 1;
        w <= 0;
      end
      if (busy && (lrs !== exp_rs || lrw !== 1'b1 || ldir !== 1'b1)) rs_bad <= rs_bad + 1;
      if (!le4 && e4_prev) npulse4 <= npulse4 + 1;
    end
  end

  task automatic clear_model(input logic r);
    @(negedge clk); clr = 1'b1; exp_rs = r;
    @(negedge clk); clr = 1'b0;
  endtask

  // lat = 1 in the cycle right after the accepting edge.
  task automatic run_txn(input logic r, input logic p, output int lat);
    clear_model(r);
    req = 1'b1; rs = r; poll = p;
    @(posedge clk); #1;
    req = 1'b0; rs = 1'b0; poll = 1'b0;
    lat = 1;
    chk("busy_rise", busy, 1'b1);
    while (!valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat, nval;
  logic hit;

  initial begin
    script = '{4'h8, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_e", le, 1'b0);    chk("rst_rw", lrw, 1'b0);
    chk("rst_rs", lrs, 1'b0);  chk("rst_dir", ldir, 1'b0);
    chk("rst_busy", busy, 1'b0); chk("rst_valid", valid, 1'b0);
    chk("rst_tmo", timeout, 1'b0); chk("rst_data", data, 8'h00);
    @(negedge clk); rst = 1'b0;

    // RS=0 busy/address read
    run_txn(1'b0, 1'b0, lat);
    chk("rs0_lat", lat, 103);
    chk("rs0_data", data, 8'h85);
    chk("rs0_tmo", timeout, 1'b0);
    chk("rs0_pulses", npulse, 2);
    chk("rs0_ewidth", bad_w, 0);
    chk("rs0_ctl", rs_bad, 0);
    @(posedge clk); #1;
    chk("rs0_vpulse", valid, 1'b0);
    chk("rs0_busy_off", busy, 1'b0);
    chk("rs0_rw_off", lrw, 1'b0);
    chk("rs0_dir_off", ldir, 1'b0);

    // RS=1 data read
    script = '{4'h4, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_txn(1'b1, 1'b0, lat);
    chk("rs1_lat", lat, 103);
    chk("rs1_data", data, 8'h41);
    chk("rs1_ctl", rs_bad, 0);
    chk("rs1_pulses", npulse, 2);

    // Poll: busy three times then clear
    script = '{4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h5};
    run_txn(1'b0, 1'b1, lat);
    chk("poll_lat", lat, 103 + 3 * 97);
    chk("poll_data", data, 8'h05);
    chk("poll_tmo", timeout, 1'b0);
    chk("poll_pulses", npulse, 8);
    chk("poll_ewidth", bad_w, 0);

    // Poll timeout on the MAX_POLLS=4 instance, BF stuck at 1
    clear_model(1'b0);
    req4 = 1'b1; poll4 = 1'b1;
    @(posedge clk); #1;
    req4 = 1'b0; poll4 = 1'b0;
    lat = 1;
    while (!valid4 && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("tmo_lat", lat, 103 + 3 * 97);
    chk("tmo_flag", timeout4, 1'b1);
    chk("tmo_bf", data4[7], 1'b1);
    chk("tmo_pulses", npulse4, 8);

    // Reset during the second E-high phase
    script = '{4'h8, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    clear_model(1'b0);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (npulse == 1 && le) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("mid_reached", hit, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_e", le, 1'b0);
    chk("mid_rw", lrw, 1'b0);
    chk("mid_dir", ldir, 1'b0);
    chk("mid_busy", busy, 1'b0);
    @(negedge clk); rst = 1'b0;
    nval = 0;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      if (valid) nval++;
    end
    chk("mid_novalid", nval, 0);
    run_txn(1'b0, 1'b0, lat);
    chk("post_lat", lat, 103);
    chk("post_data", data, 8'h85);

    // i_req pulses during SETUP and HOLD must be ignored
    script = '{4'h2, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    clear_model(1'b0);
    req = 1'b1;
    @(posedge clk); #1;
    nval = 0;
    for (int c = 1; c <= 300; c++) begin
      if (valid) nval++;
      req = (c == 2 || c == 101);
      @(posedge clk); #1;
    end
    req = 1'b0;
    chk("ign_nvalid", nval, 1);
    chk("ign_data", data, 8'h27);
    chk("ign_pulses", npulse, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
